fake_mem_noc3_delay_buf: RTL

Latency-injecting response buffer placed directly downstream of the fake AXI4 memory model's NoC3 output and upstream of the chip's NoC3 return path. It accepts whole OpenPiton response packets (header plus payload flits) and stores them. It releases each packet only after a configurable number of cycles has elapsed since its header arrived. This models realistic DRAM latency and back-pressure in simulation. Packet order is strictly preserved.

---
 rtl/fake_mem_noc3_delay_buf.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/fake_mem_noc3_delay_buf.sv
// fake_mem_noc3_delay_buf: holds whole NoC3 response packets from the fake
// memory and releases each one a programmable number of cycles after its
// header arrived, strictly in arrival order.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_val/in_dat/in_rdy  NoC3 flits from the fake memory
//   out_val/out_dat/out_rdy delayed NoC3 flits toward the chip
//   cfg_delay_en          1: use cfg_delay, 0: use DEFAULT_DELAY
//   cfg_delay             header-to-header latency, sampled at header accept
//   pkt_count             packets held, including the one being drained
//
// Optional feature: define FAKE_MEM_DELAY_JITTER_EN to add 0-31 cycles of
// LFSR-driven jitter to each packet's delay.

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef MSG_LENGTH_HI
`define MSG_LENGTH_HI 29
`endif
`ifndef MSG_LENGTH_LO
`define MSG_LENGTH_LO 22
`endif

module fake_mem_noc3_delay_buf #(
    parameter int FLIT_DEPTH    = 64,
    parameter int PKT_DEPTH     = 16,
    parameter int TS_W          = 16,
    parameter int DEFAULT_DELAY = 100
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_val,
    input  logic [`NOC_DATA_WIDTH-1:0]  in_dat,
    output logic                        in_rdy,
    output logic                        out_val,
    output logic [`NOC_DATA_WIDTH-1:0]  out_dat,
    input  logic                        out_rdy,
    input  logic                        cfg_delay_en,
    input  logic [TS_W-1:0]             cfg_delay,
    output logic [$clog2(PKT_DEPTH):0]  pkt_count
);

    localparam int DW  = `NOC_DATA_WIDTH;
    localparam int LW  = `MSG_LENGTH_HI - `MSG_LENGTH_LO + 1;
    localparam int FAW = $clog2(FLIT_DEPTH);
    localparam int PAW = $clog2(PKT_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TS_W-1:0] ts_q;
    logic            run_q;
    logic [LW-1:0]   rem_q;
    logic [FAW:0]    fwr_q;
    logic [FAW:0]    frd_q;
    logic [PAW:0]    pwr_q;
    logic [PAW:0]    prd_q;
    state_e          state_q;
    logic [LW:0]     cnt_q;

    logic [DW-1:0]   flit_mem [FLIT_DEPTH];
    logic [TS_W-1:0] pts_mem  [PKT_DEPTH];
    logic [LW-1:0]   plen_mem [PKT_DEPTH];

    // ------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------
    logic [FAW:0] flit_cnt;
    logic         flit_full;
    logic         flit_empty;
    logic         pkt_full;
    logic         pkt_empty;

    assign flit_cnt   = fwr_q - frd_q;
    assign flit_full  = flit_cnt == (FAW + 1)'(FLIT_DEPTH);
    assign flit_empty = fwr_q == frd_q;
    assign pkt_count  = pwr_q - prd_q;
    assign pkt_full   = pkt_count == (PAW + 1)'(PKT_DEPTH);
    assign pkt_empty  = pwr_q == prd_q;

    // ------------------------------------------------------------------
    // Ingress
    // ------------------------------------------------------------------
    logic            push;
    logic            is_hdr;
    logic [LW-1:0]   hdr_len;
    logic [TS_W-1:0] base_delay;
    logic [TS_W-1:0] delay;
    logic [TS_W-1:0] rel_ts;

    // run_q keeps in_rdy low while in reset and for the first cycle after,
    // while still being a pure function of registered state.
    // A payload flit never needs a packet-info slot, so only headers
    // are gated by pkt_full.
    assign in_rdy  = run_q && !flit_full && (rem_q != '0 || !pkt_full);
    assign push    = in_val && in_rdy;
    assign is_hdr  = rem_q == '0;
    assign hdr_len = in_dat[`MSG_LENGTH_HI:`MSG_LENGTH_LO];

    assign base_delay = cfg_delay_en ? cfg_delay : TS_W'(DEFAULT_DELAY);

`ifdef FAKE_MEM_DELAY_JITTER_EN
    logic [15:0] lfsr_q;
    assign delay = base_delay + TS_W'(lfsr_q[4:0]);
`else
    assign delay = base_delay;
`endif

    assign rel_ts = ts_q + delay;

    // ------------------------------------------------------------------
    // Egress
    // ------------------------------------------------------------------
    logic [TS_W-1:0] head_ts;
    logic [LW-1:0]   head_len;
    logic [TS_W-1:0] age;
    logic            due;
    logic            pop;
    logic            last;

    assign head_ts  = pts_mem[prd_q[PAW-1:0]];
    assign head_len = plen_mem[prd_q[PAW-1:0]];

    // Wrap-safe "now >= release": the TS_W-bit difference is treated as
    // signed, so it holds as long as delays stay below 2^(TS_W-1).
    assign age = ts_q - head_ts;
    assign due = $signed(age) >= $signed({TS_W{1'b0}});

    assign out_val = (state_q == S_SEND) && !flit_empty;
    assign out_dat = out_val ? flit_mem[frd_q[FAW-1:0]] : '0;
    assign pop     = out_val && out_rdy;
    assign last    = pop && (cnt_q == (LW + 1)'(1));

    // ------------------------------------------------------------------
    // Storage arrays (no reset; validity comes from the pointers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            flit_mem[fwr_q[FAW-1:0]] <= in_dat;
        end
        if (push && is_hdr) begin
            pts_mem[pwr_q[PAW-1:0]]  <= rel_ts;
            plen_mem[pwr_q[PAW-1:0]] <= hdr_len;
        end
    end

    // ------------------------------------------------------------------
    // Control state and egress FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q    <= '0;
            run_q   <= 1'b0;
            rem_q   <= '0;
            fwr_q   <= '0;
            frd_q   <= '0;
            pwr_q   <= '0;
            prd_q   <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
`ifdef FAKE_MEM_DELAY_JITTER_EN
            lfsr_q  <= 16'hACE1;
`endif
        end else begin
            ts_q  <= ts_q + TS_W'(1);
            run_q <= 1'b1;
`ifdef FAKE_MEM_DELAY_JITTER_EN
            // Galois form of x^16+x^14+x^13+x^11+1
            lfsr_q <= {1'b0, lfsr_q[15:1]}
                    ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
`endif
            if (push) begin
                fwr_q <= fwr_q + (FAW + 1)'(1);
                if (is_hdr) begin
                    rem_q <= hdr_len;
                    pwr_q <= pwr_q + (PAW + 1)'(1);
                end else begin
                    rem_q <= rem_q - LW'(1);
                end
            end
            if (pop) begin
                frd_q <= frd_q + (FAW + 1)'(1);
            end
            if (last) begin
                prd_q <= prd_q + (PAW + 1)'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (!pkt_empty && due) begin
                        state_q <= S_SEND;
                        cnt_q   <= {1'b0, head_len} + (LW + 1)'(1);
                    end
                end
                S_SEND: begin
                    if (pop) begin
                        cnt_q <= cnt_q - (LW + 1)'(1);
                        if (last) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
